// File: rtl/puf_eval_controller.sv
// Sequencer for one RO-PUF evaluation per accepted challenge: clear, run, settle, hold result.
// Define PUF_MAJORITY_VOTE_EN to evaluate each challenge three times and return the bitwise majority.
module puf_eval_controller #(
    parameter int unsigned RST_CYCLES     = 4,
    parameter int unsigned SETTLE_CYCLES  = 2,
    parameter int unsigned TIMEOUT_CYCLES = 8000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ch_valid,
    output logic       ch_ready,
    input  logic [7:0] ch_data,
    output logic [7:0] puf_challenge,
    output logic       puf_enable,
    output logic       puf_reset,
    input  logic       puf_done,
    input  logic [7:0] puf_response,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_timeout,
    output logic       busy
);

    localparam int unsigned MaxShort = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
    localparam int unsigned MaxCnt   = (TIMEOUT_CYCLES > MaxShort) ? TIMEOUT_CYCLES : MaxShort;
    localparam int unsigned CntW     = $clog2(MaxCnt + 1);

    localparam logic [CntW-1:0] RstLast    = CntW'(RST_CYCLES - 1);
    localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYCLES - 1);
    localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StRun,
        StSettle,
        StHold
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      chal_q, chal_d;
    logic [7:0]      data_q, data_d;
    logic            tout_q, tout_d;

    logic            done_meta, done_s;
    logic [7:0]      resp_meta, resp_s;

`ifdef PUF_MAJORITY_VOTE_EN
    logic [1:0]      pass_q, pass_d;
    logic [7:0]      samp0_q, samp0_d;
    logic [7:0]      samp1_q, samp1_d;
    logic [7:0]      majority;

    assign majority = (samp0_q & samp1_q) | (samp0_q & resp_s) | (samp1_q & resp_s);
`endif

    // Both PUF outputs are asynchronous to clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_meta <= 1'b0;
            done_s    <= 1'b0;
            resp_meta <= 8'h00;
            resp_s    <= 8'h00;
        end else begin
            done_meta <= puf_done;
            done_s    <= done_meta;
            resp_meta <= puf_response;
            resp_s    <= resp_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            chal_q  <= 8'h00;
            data_q  <= 8'h00;
            tout_q  <= 1'b0;
`ifdef PUF_MAJORITY_VOTE_EN
            pass_q  <= 2'd0;
            samp0_q <= 8'h00;
            samp1_q <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            chal_q  <= chal_d;
            data_q  <= data_d;
            tout_q  <= tout_d;
`ifdef PUF_MAJORITY_VOTE_EN
            pass_q  <= pass_d;
            samp0_q <= samp0_d;
            samp1_q <= samp1_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        chal_d  = chal_q;
        data_d  = data_q;
        tout_d  = tout_q;
`ifdef PUF_MAJORITY_VOTE_EN
        pass_d  = pass_q;
        samp0_d = samp0_q;
        samp1_d = samp1_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (ch_valid) begin
                    chal_d  = ch_data;
                    cnt_d   = '0;
                    state_d = StClear;
`ifdef PUF_MAJORITY_VOTE_EN
                    pass_d  = 2'd0;
`endif
                end
            end
            StClear: begin
                if (cnt_q == RstLast) begin
                    cnt_d   = '0;
                    state_d = StRun;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRun: begin
                // A done seen on the timeout cycle still counts as a valid result.
                if (done_s) begin
                    cnt_d   = '0;
                    state_d = StSettle;
                end else if (cnt_q == TimeoutCnt) begin
                    cnt_d   = '0;
                    data_d  = 8'h00;
                    tout_d  = 1'b1;
                    state_d = StHold;
`ifdef PUF_MAJORITY_VOTE_EN
                    pass_d  = 2'd0;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StSettle: begin
                if (cnt_q == SettleLast) begin
                    cnt_d = '0;
`ifdef PUF_MAJORITY_VOTE_EN
                    case (pass_q)
                        2'd0: begin
                            samp0_d = resp_s;
                            pass_d  = 2'd1;
                            state_d = StClear;
                        end
                        2'd1: begin
                            samp1_d = resp_s;
                            pass_d  = 2'd2;
                            state_d = StClear;
                        end
                        default: begin
                            data_d  = majority;
                            tout_d  = 1'b0;
                            pass_d  = 2'd0;
                            state_d = StHold;
                        end
                    endcase
`else
                    data_d  = resp_s;
                    tout_d  = 1'b0;
                    state_d = StHold;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StHold: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decode only registered state, so no input reaches an output combinationally.
    assign ch_ready      = (state_q == StIdle);
    assign busy          = (state_q != StIdle);
    assign rsp_valid     = (state_q == StHold);
    assign puf_enable    = (state_q == StRun) || (state_q == StSettle);
    assign puf_reset     = !((state_q == StRun) || (state_q == StSettle));
    assign puf_challenge = chal_q;
    assign rsp_data      = data_q;
    assign rsp_timeout   = tout_q;

endmodule
